pmod_button_reader: RTL and testbench

//  Input-side companion to the PMOD LED chaser. Samples 8 active-low buttons on PMOD1..PMOD8,

---
 rtl/pmod_button_reader_if.sv | 11 +
 rtl/pmod_button_reader.sv | 119 +++++++++++
 tb/tb_pmod_button_reader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pmod_button_reader_if.sv
// Event handshake between the button reader and its consumer.
// The reader drives valid/key/press, and the consumer drives ready.
interface pmod_button_reader_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic       evt_press;

  modport master (output evt_valid, output evt_key, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_press, output evt_ready);
endinterface

// File: rtl/pmod_button_reader.sv
// Synchronises and debounces eight active-low PMOD buttons, then queues
// each debounced press or release in a small show-ahead event FIFO.
module pmod_button_reader #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        PMOD1,
  input  logic                        PMOD2,
  input  logic                        PMOD3,
  input  logic                        PMOD4,
  input  logic                        PMOD5,
  input  logic                        PMOD6,
  input  logic                        PMOD7,
  input  logic                        PMOD8,
  output logic [7:0]                  key_state,
  output logic                        overflow,
  pmod_button_reader_if.master        evt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       raw;
  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       key_q, key_d;
  logic [7:0]       pend_q, pend_d, pendSet, pendClr;
  logic [7:0]       pdir_q, pdir_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             push, doPush, pop, full, empty;
  logic [2:0]       pushIdx;

  // Bit order follows the LED chaser layout so key i lines up with LED i.
  assign raw = ~{PMOD7, PMOD5, PMOD3, PMOD1, PMOD8, PMOD6, PMOD4, PMOD2};

  always_comb begin
    key_d   = key_q;
    pdir_d  = pdir_q;
    pendSet = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == key_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        key_d[i]   = sync2_q[i];
        cnt_d[i]   = '0;
        pendSet[i] = 1'b1;
        pdir_d[i]  = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Lowest-index pending change wins; scanning downward leaves the lowest set bit.
  always_comb begin
    pushIdx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) pushIdx = 3'(i);
    end
    push    = |pend_q;
    pendClr = push ? (8'd1 << pushIdx) : 8'd0;
    pend_d  = (pend_q & ~pendClr) | pendSet;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign pop   = !empty && evt.evt_ready;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush     = push && (!full || pop);
  assign overflow_d = overflow_q | (push && full && !pop);
  assign wptr_d     = doPush ? wptr_q + PTR_W'(1) : wptr_q;
  assign rptr_d     = pop ? rptr_q + PTR_W'(1) : rptr_q;
  assign count_d    = count_q + (PTR_W+1)'(doPush) - (PTR_W+1)'(pop);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      key_q      <= '0;
      pend_q     <= '0;
      pdir_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      key_q      <= key_d;
      pend_q     <= pend_d;
      pdir_q     <= pdir_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      if (doPush) mem_q[wptr_q] <= {pushIdx, pdir_q[pushIdx]};
    end
  end

  assign key_state     = key_q;
  assign overflow      = overflow_q;
  assign evt.evt_valid = !empty;
  assign evt.evt_key   = mem_q[rptr_q][3:1];
  assign evt.evt_press = mem_q[rptr_q][0];

endmodule

// File: tb/tb_pmod_button_reader.sv
// Directed bench for pmod_button_reader with a 16-cycle debounce:
// covers reset, latency, glitch rejection, arbitration, overflow and reset mid-activity.
module tb_pmod_button_reader;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [8:1] pins;
  logic [7:0] keyState;
  logic       overflow;
  int         assertCount = 0;
  int         failCount   = 0;

  pmod_button_reader_if bus ();

  pmod_button_reader #(
    .DEBOUNCE_CYCLES (16),
    .CNT_W           (5),
    .FIFO_DEPTH      (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .PMOD1     (pins[1]),
    .PMOD2     (pins[2]),
    .PMOD3     (pins[3]),
    .PMOD4     (pins[4]),
    .PMOD5     (pins[5]),
    .PMOD6     (pins[6]),
    .PMOD7     (pins[7]),
    .PMOD8     (pins[8]),
    .key_state (keyState),
    .overflow  (overflow),
    .evt       (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [8:1] levels, input logic ready);
    pins          = levels;
    bus.evt_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] headWord();
    return {3'b000, bus.evt_valid, bus.evt_key, bus.evt_press};
  endfunction

  function automatic logic [7:0] expEvt(input logic [2:0] key, input logic press);
    return {3'b000, 1'b1, key, press};
  endfunction

  initial begin
    // Test 1: reset with all pins idle, then a quiet period.
    $display("[TB] reset and idle");
    RST_N = 1'b0;
    applyStimulus(8'hFF, 1'b0);
    tick(3);
    checkOutput("rst key_state", keyState, 8'h00);
    checkOutput("rst valid", {7'd0, bus.evt_valid}, 8'h00);
    checkOutput("rst overflow", {7'd0, overflow}, 8'h00);
    checkOutput("rst head", {4'd0, bus.evt_key, bus.evt_press}, 8'h00);
    RST_N = 1'b1;
    tick(100);
    checkOutput("idle key_state", keyState, 8'h00);
    checkOutput("idle valid", {7'd0, bus.evt_valid}, 8'h00);

    // Test 2: PMOD1 press lands on key 4 after 2 + 16 edges.
    $display("[TB] single press latency");
    applyStimulus(8'hFE, 1'b1);
    tick(17);
    checkOutput("t2 early", keyState, 8'h00);
    tick(1);
    checkOutput("t2 key_state", keyState, 8'h10);
    checkOutput("t2 no evt yet", {7'd0, bus.evt_valid}, 8'h00);
    tick(1);
    checkOutput("t2 evt", headWord(), expEvt(3'd4, 1'b1));
    tick(1);
    checkOutput("t2 popped", {7'd0, bus.evt_valid}, 8'h00);
    tick(20);
    checkOutput("t2 one evt", {7'd0, bus.evt_valid}, 8'h00);

    // Test 3: a 10-cycle glitch on PMOD3 is ignored, a held press is not.
    $display("[TB] glitch rejection");
    applyStimulus(8'hFA, 1'b1);
    tick(10);
    applyStimulus(8'hFE, 1'b1);
    tick(30);
    checkOutput("t3 glitch key", keyState, 8'h10);
    checkOutput("t3 glitch evt", {7'd0, bus.evt_valid}, 8'h00);
    applyStimulus(8'hFA, 1'b1);
    tick(17);
    checkOutput("t3 early", keyState, 8'h10);
    tick(1);
    checkOutput("t3 key_state", keyState, 8'h30);
    tick(1);
    checkOutput("t3 evt", headWord(), expEvt(3'd5, 1'b1));
    tick(1);
    checkOutput("t3 popped", {7'd0, bus.evt_valid}, 8'h00);

    // Test 4: PMOD7, PMOD2, PMOD6 together drain lowest index first.
    $display("[TB] simultaneous presses");
    applyStimulus(8'h98, 1'b1);
    tick(18);
    checkOutput("t4 key_state", keyState, 8'hB5);
    tick(1);
    checkOutput("t4 evt0", headWord(), expEvt(3'd0, 1'b1));
    tick(1);
    checkOutput("t4 evt2", headWord(), expEvt(3'd2, 1'b1));
    tick(1);
    checkOutput("t4 evt7", headWord(), expEvt(3'd7, 1'b1));
    tick(1);
    checkOutput("t4 drained", {7'd0, bus.evt_valid}, 8'h00);

    // Test 5: five releases with ready low; the fifth overflows.
    $display("[TB] overflow");
    applyStimulus(8'hFF, 1'b0);
    tick(18);
    checkOutput("t5 key_state", keyState, 8'h00);
    tick(4);
    checkOutput("t5 head", headWord(), expEvt(3'd0, 1'b0));
    checkOutput("t5 no ovf yet", {7'd0, overflow}, 8'h00);
    tick(1);
    checkOutput("t5 overflow", {7'd0, overflow}, 8'h01);
    tick(5);
    checkOutput("t5 held head", headWord(), expEvt(3'd0, 1'b0));
    applyStimulus(8'hFF, 1'b1);
    tick(1);
    checkOutput("t5 pop2", headWord(), expEvt(3'd2, 1'b0));
    tick(1);
    checkOutput("t5 pop4", headWord(), expEvt(3'd4, 1'b0));
    tick(1);
    checkOutput("t5 pop5", headWord(), expEvt(3'd5, 1'b0));
    tick(1);
    checkOutput("t5 empty", {7'd0, bus.evt_valid}, 8'h00);
    checkOutput("t5 sticky", {7'd0, overflow}, 8'h01);

    // Test 6: reset with three queued events and PMOD1 mid-debounce.
    $display("[TB] reset mid-activity");
    applyStimulus(8'h67, 1'b0);
    tick(18);
    checkOutput("t6 key_state", keyState, 8'h4A);
    tick(3);
    checkOutput("t6 queued head", headWord(), expEvt(3'd1, 1'b1));
    applyStimulus(8'h66, 1'b0);
    tick(5);
    RST_N = 1'b0;
    tick(1);
    checkOutput("t6 rst valid", {7'd0, bus.evt_valid}, 8'h00);
    checkOutput("t6 rst overflow", {7'd0, overflow}, 8'h00);
    checkOutput("t6 rst key_state", keyState, 8'h00);
    RST_N = 1'b1;
    tick(17);
    checkOutput("t6 early", keyState, 8'h00);
    tick(1);
    checkOutput("t6 reassert", keyState, 8'h5A);
    tick(1);
    checkOutput("t6 new evt", headWord(), expEvt(3'd1, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
